demux1x8_deser_with_en: RTL and testbench
=========================================

Name: demux1x8_deser_with_en

Overview:
Registered 1-to-8 demultiplexer and deserialiser with an active-low enable. It is the receive-side inverse of the 8:1 enabled mux. A serial bit stream is steered into output positions 0..N-1 by an internal select counter, LSB first. It emits the assembled word with a one-cycle valid pulse. It sits downstream of a mux-based serialiser: a mux whose select counts 0..7, feeding this block, round-trips the data unchanged.

Parameters:
N, 8, number of demux outputs / word width; power of two, at least 2
SEL_W, $clog2(N), localparam (not overridable), select/counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  active-low enable; 1 = block disabled
din_vld  input  1  datain is valid this cycle
sof  input  1  start of frame; qualified by din_vld; forces the bit into position 0
datain  input  1  serial data bit
dataout  output  N  live demux register of the current partial frame; forced to 0 while en=1
word_out  output  N  last completed word; registered
word_vld  output  1  one-cycle pulse; word_out updated this cycle
sel  output  SEL_W  position the next valid bit will be written to
busy  output  1  1 while in FILL

Behaviour:
- Reset (rst_n=0, async): state=IDLE, sel=0, internal data register=0, word_out=0, word_vld=0, busy=0.
- States:
  - IDLE: sel=0, no partial frame.
  - FILL: sel in 1..N-1.
- Capture condition: en=0 and din_vld=1. All updates occur on the rising clk edge.
- IDLE, capture: data reg cleared, then data_reg[0]=datain; sel<=1; go to FILL. sof is irrelevant in IDLE.
- FILL, capture, sof=0: data_reg[sel]=datain; sel<=sel+1.
  - If sel was N-1: word_out<=data_reg with bit N-1 = datain; word_vld<=1 next cycle; sel wraps to 0; go to IDLE.
  - Latency: word_vld is high in the cycle directly after the edge that captured the final bit.
- FILL, capture, sof=1: partial frame discarded; data reg cleared, data_reg[0]=datain; sel<=1; stay in FILL. No word_vld.
- din_vld=0 with en=0: everything holds; word_vld=0.
- en=1 (disabled): next edge aborts any partial frame.
  - sel<=0, data reg<=0, state<=IDLE, word_vld<=0.
  - word_out retains the last completed word.
  - dataout is combinationally 0 whenever en=1.
- word_vld is never high two cycles in a row unless N=... (cannot occur for N>=2). Back-to-back frames give a pulse every N cycles.
- dataout (en=0) = data_reg: bits not yet written in the current frame read 0.
- Async reset mid-frame: immediate clear of everything listed under Reset; no word_vld.
- Bit order: first bit of a frame goes to bit 0, matching mux select 0 -> datain[0].

Decomposition:
- Shared package demux_pkg:
  - state enum {IDLE, FILL};
  - default N constant;
  - SEL_W derivation function.
- One natural sub-module, demux_sel_cnt: SEL_W-bit counter with inc, load-to-1 and clear inputs, plus a terminal-count output (sel==N-1).
- Data register, capture logic and FSM stay in the top level.

Test Plan:
1. rst_n=0 with random inputs -> all outputs 0. Release with din_vld=0 for 10 cycles -> sel=0, busy=0, word_vld never asserted.
2. en=0, consecutive bits 1,0,1,1,0,0,1,0 with din_vld=1 -> sel steps 1..7 then 0; word_vld one cycle after the 8th edge; word_out=8'h4D; dataout shows partial bits during the fill.
3. Same byte with random din_vld gaps of 1-3 cycles -> sel and dataout hold during gaps; word_out=8'h4D; exactly one word_vld pulse.
4. 3 bits captured, then en=1 for 2 cycles -> dataout=0, sel=0, busy=0, no word_vld, word_out unchanged. en=0, send 0xA5 LSB-first -> word_out=8'hA5.
5. 5 garbage bits, then sof=1 with datain=1, then bits for 0x3C's bits 1..7 -> sel=1 after sof; exactly one word_vld; word_out=8'h3D.
6. Back-to-back 0xFF then 0x00 with no gaps -> word_vld at cycles 9 and 17 after the first capture, with word_out 8'hFF then 8'h00. A third byte with rst_n pulsed low asynchronously after bit 4 -> immediate clear, no word_vld, and the next full byte deserialises correctly.

Source files
------------

// File: rtl/demux1x8_deser_with_en_pkg.sv
// demux1x8_deser_with_en_pkg: shared state encoding, default width and select-width helper
package demux1x8_deser_with_en_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_e;
  localparam int DEF_N = 8;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/demux1x8_deser_with_en_if.sv
// demux1x8_deser_with_en_if: serial input and deserialised output bundle
interface demux1x8_deser_with_en_if
  import demux1x8_deser_with_en_pkg::*;
#(parameter int N = DEF_N);
  localparam int SEL_W = sel_w(N);
  logic en;
  logic din_vld;
  logic sof;
  logic datain;
  logic [N-1:0] dataout;
  logic [N-1:0] word_out;
  logic word_vld;
  logic [SEL_W-1:0] sel;
  logic busy;
  modport master (output en, din_vld, sof, datain, input dataout, word_out, word_vld, sel, busy);
  modport slave (input en, din_vld, sof, datain, output dataout, word_out, word_vld, sel, busy);
endinterface

// File: rtl/demux1x8_deser_with_en_sel_cnt.sv
// demux1x8_deser_with_en_sel_cnt: bit-position counter with clear, load-to-1 and increment
module demux1x8_deser_with_en_sel_cnt #(
  parameter int N = 8,
  parameter int SEL_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic load1_i,
  input  logic clr_i,
  output logic [SEL_W-1:0] sel_o,
  output logic tc_o
);
  logic [SEL_W-1:0] sel_q, sel_d;
  // N is a power of two, so the increment past N-1 wraps to 0 by itself
  assign sel_d = clr_i ? '0 : load1_i ? SEL_W'(1) : inc_i ? sel_q + SEL_W'(1) : sel_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= '0;
    else sel_q <= sel_d;
  end
  assign sel_o = sel_q;
  assign tc_o = sel_q == SEL_W'(N - 1);
endmodule

// File: rtl/demux1x8_deser_with_en.sv
// demux1x8_deser_with_en: registered 1-to-N demux/deserialiser with active-low enable
module demux1x8_deser_with_en
  import demux1x8_deser_with_en_pkg::*;
#(parameter int N = DEF_N) (
  input logic clk,
  input logic rst_n,
  demux1x8_deser_with_en_if.slave bus
);
  localparam int SEL_W = sel_w(N);
  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_FILL = 1'(FILL);
  logic [0:0] state_q, state_d;
  logic [N-1:0] data_q, data_d, word_q, word_d;
  logic vld_q, vld_d;
  logic cap, load1, inc, tc;
  logic [SEL_W-1:0] sel;
  assign cap = !bus.en && bus.din_vld;
  // a capture in IDLE and an sof in FILL both restart the frame at bit 0
  assign load1 = cap && (state_q == S_IDLE || bus.sof);
  assign inc = cap && state_q == S_FILL && !bus.sof;
  demux1x8_deser_with_en_sel_cnt #(.N(N), .SEL_W(SEL_W)) u_sel_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .inc_i(inc),
    .load1_i(load1),
    .clr_i(bus.en),
    .sel_o(sel),
    .tc_o(tc)
  );
  always_comb begin
    data_d = data_q;
    word_d = word_q;
    vld_d = 1'b0;
    state_d = state_q;
    if (bus.en) begin
      data_d = '0;
      state_d = S_IDLE;
    end else if (load1) begin
      data_d = N'(bus.datain);
      state_d = S_FILL;
    end else if (inc) begin
      data_d[sel] = bus.datain;
      if (tc) begin
        word_d = data_d;
        vld_d = 1'b1;
        data_d = '0;
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q <= '0;
      word_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      word_q <= word_d;
      vld_q <= vld_d;
    end
  end
  assign bus.dataout = bus.en ? '0 : data_q;
  assign bus.word_out = word_q;
  assign bus.word_vld = vld_q;
  assign bus.sel = sel;
  assign bus.busy = state_q == S_FILL;
endmodule

// File: tb/tb_demux1x8_deser_with_en.sv
// tb_demux1x8_deser_with_en: directed table-driven bench for the 1-to-8 deserialiser
module tb_demux1x8_deser_with_en;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux1x8_deser_with_en_if #(.N(N)) bus ();
  demux1x8_deser_with_en #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic en, vld, sof, din;
    logic [2:0] sel;
    logic [7:0] dout;
    logic wv;
    logic [7:0] word;
    logic busy;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input logic en, vld, sof, din, input logic [2:0] sel,
                             input logic [7:0] dout, input logic wv, input logic [7:0] word,
                             input logic busy);
    vec_t r;
    r.en = en; r.vld = vld; r.sof = sof; r.din = din; r.sel = sel;
    r.dout = dout; r.wv = wv; r.word = word; r.busy = busy;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [2:0] sel, input logic [7:0] dout,
                           input logic wv, input logic [7:0] word, input logic busy);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(sel));
    chk({tag, ".dataout"}, 32'(bus.dataout), 32'(dout));
    chk({tag, ".word_vld"}, 32'(bus.word_vld), 32'(wv));
    chk({tag, ".word_out"}, 32'(bus.word_out), 32'(word));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
  endtask
  task automatic drive(input logic en, vld, sof, din);
    bus.en = en; bus.din_vld = vld; bus.sof = sof; bus.datain = din;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].en, tbl[i].vld, tbl[i].sof, tbl[i].din);
      check_all($sformatf("row%0d", i), tbl[i].sel, tbl[i].dout, tbl[i].wv, tbl[i].word, tbl[i].busy);
    end
  endtask
  initial begin
    int pulses;
    logic [7:0] p;
    logic [7:0] b;
    // 0x4D LSB first, then idle
    tbl.push_back(v(0,1,0,1, 1,8'h01,0,8'h00,1));
    tbl.push_back(v(0,1,0,0, 2,8'h01,0,8'h00,1));
    tbl.push_back(v(0,1,0,1, 3,8'h05,0,8'h00,1));
    tbl.push_back(v(0,1,0,1, 4,8'h0D,0,8'h00,1));
    tbl.push_back(v(0,1,0,0, 5,8'h0D,0,8'h00,1));
    tbl.push_back(v(0,1,0,0, 6,8'h0D,0,8'h00,1));
    tbl.push_back(v(0,1,0,1, 7,8'h4D,0,8'h00,1));
    tbl.push_back(v(0,1,0,0, 0,8'h00,1,8'h4D,0));
    tbl.push_back(v(0,0,0,1, 0,8'h00,0,8'h4D,0));
    // rows 9..: 3 bits, disable for 2 cycles, then 0xA5
    tbl.push_back(v(0,1,0,1, 1,8'h01,0,8'h4D,1));
    tbl.push_back(v(0,1,0,1, 2,8'h03,0,8'h4D,1));
    tbl.push_back(v(0,1,0,0, 3,8'h03,0,8'h4D,1));
    tbl.push_back(v(1,1,0,1, 0,8'h00,0,8'h4D,0));
    tbl.push_back(v(1,1,1,1, 0,8'h00,0,8'h4D,0));
    tbl.push_back(v(0,1,0,1, 1,8'h01,0,8'h4D,1));
    tbl.push_back(v(0,1,0,0, 2,8'h01,0,8'h4D,1));
    tbl.push_back(v(0,1,0,1, 3,8'h05,0,8'h4D,1));
    tbl.push_back(v(0,1,0,0, 4,8'h05,0,8'h4D,1));
    tbl.push_back(v(0,1,0,0, 5,8'h05,0,8'h4D,1));
    tbl.push_back(v(0,1,0,1, 6,8'h25,0,8'h4D,1));
    tbl.push_back(v(0,1,0,0, 7,8'h25,0,8'h4D,1));
    tbl.push_back(v(0,1,0,1, 0,8'h00,1,8'hA5,0));
    // 5 garbage bits (sof in IDLE ignored), sof restart, then bits 1..7 of 0x3C
    tbl.push_back(v(0,1,1,1, 1,8'h01,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 2,8'h03,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 3,8'h07,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 4,8'h0F,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 5,8'h1F,0,8'hA5,1));
    tbl.push_back(v(0,1,1,1, 1,8'h01,0,8'hA5,1));
    tbl.push_back(v(0,1,0,0, 2,8'h01,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 3,8'h05,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 4,8'h0D,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 5,8'h1D,0,8'hA5,1));
    tbl.push_back(v(0,1,0,1, 6,8'h3D,0,8'hA5,1));
    tbl.push_back(v(0,1,0,0, 7,8'h3D,0,8'hA5,1));
    tbl.push_back(v(0,1,0,0, 0,8'h00,1,8'h3D,0));
    tbl.push_back(v(0,0,0,0, 0,8'h00,0,8'h3D,0));
    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.en = 1'($urandom); bus.din_vld = 1'($urandom);
      bus.sof = 1'($urandom); bus.datain = 1'($urandom);
      @(negedge clk);
      check_all($sformatf("rst%0d", i), 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    bus.en = 1'b0; bus.din_vld = 1'b0; bus.sof = 1'b0; bus.datain = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1'($urandom));
      check_all($sformatf("idle%0d", i), 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    run_rows(0, 8);
    // same byte with 1-3 cycle gaps; sof/datain toggling while din_vld=0 must be ignored
    b = 8'h4D;
    p = 8'h00;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        drive(0, 0, 1'($urandom), 1'($urandom));
        pulses += int'(bus.word_vld);
        chk($sformatf("gap%0d.sel", i), 32'(bus.sel), 32'(i));
        chk($sformatf("gap%0d.dataout", i), 32'(bus.dataout), 32'(p));
      end
      drive(0, 1, 0, b[i]);
      pulses += int'(bus.word_vld);
      p[i] = b[i];
      chk($sformatf("gbit%0d.sel", i), 32'(bus.sel), 32'((i + 1) % 8));
      chk($sformatf("gbit%0d.dataout", i), 32'(bus.dataout), 32'(i == 7 ? 8'h00 : p));
    end
    chk("gap.word_out", 32'(bus.word_out), 32'h4D);
    drive(0, 0, 0, 0);
    pulses += int'(bus.word_vld);
    chk("gap.pulses", 32'(pulses), 32'd1);
    run_rows(9, int'(tbl.size()) - 1);
    // back-to-back 0xFF then 0x00
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 0, k <= 8);
      chk($sformatf("b2b%0d.sel", k), 32'(bus.sel), 32'(k % 8));
      chk($sformatf("b2b%0d.word_vld", k), 32'(bus.word_vld), 32'(k % 8 == 0));
      chk($sformatf("b2b%0d.word_out", k), 32'(bus.word_out),
          32'(k < 8 ? 8'h3D : k < 16 ? 8'hFF : 8'h00));
    end
    // third byte aborted by async reset after bit 4
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 1);
    check_all("pre_arst", 3'd4, 8'h0F, 1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all("arst", 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_arst.word_vld", 32'(bus.word_vld), 32'd0);
    b = 8'h96;
    for (int i = 0; i < 8; i++) drive(0, 1, 0, b[i]);
    check_all("after_arst", 3'd0, 8'h00, 1'b1, 8'h96, 1'b0);
    drive(0, 0, 0, 0);
    chk("after_arst.pulse_end", 32'(bus.word_vld), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
